// File: rtl/pad_absorb_deserializer.sv
// pad_absorb_deserializer
//   Collects INWIDTH-bit message words into RATE-bit blocks. After the last word
//   of each message it appends word-granular pad10*1 padding. Completed blocks
//   leave one at a time through a single-entry output register.
//
// Ports
//   clk        rising-edge clock
//   clear      synchronous active-high reset
//   in_data    message word
//   in_valid   in_data is valid
//   in_last    in_data is the final word of its message
//   in_ready   a word is accepted this cycle when in_valid is also high
//   blk_data   assembled block; word j at [j*INWIDTH +: INWIDTH]
//   blk_valid  blk_data holds an unconsumed block
//   blk_last   block carries the padding end of its message
//   blk_ready  consumer takes the block
//   blk_count  zero-based block index within its message
//   busy       message partially collected or padding in progress
module pad_absorb_deserializer #(
    parameter int unsigned INWIDTH = 8,
    parameter int unsigned RATE    = 256,
    parameter int unsigned CNTW    = 16
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [INWIDTH-1:0] in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [RATE-1:0]    blk_data,
    output logic               blk_valid,
    output logic               blk_last,
    input  logic               blk_ready,
    output logic [CNTW-1:0]    blk_count,
    output logic               busy
);

    localparam int unsigned W   = RATE / INWIDTH;
    localparam int unsigned WCW = (W > 1) ? $clog2(W) : 1;
    localparam logic [WCW-1:0] WC_LAST = WCW'(W - 1);
    // Only slots 0..W-2 are held; slot W-1 goes straight into the output register.
    localparam int unsigned BUFW = RATE - INWIDTH;

    generate
        if ((RATE % INWIDTH) != 0 || W < 2) begin : g_bad_cfg
            $error("pad_absorb_deserializer: RATE must be a multiple of INWIDTH with RATE/INWIDTH >= 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PAD     = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WCW-1:0]    wc_q, wc_d;
    logic [BUFW-1:0]   buf_q, buf_d;
    logic              first_q, first_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [RATE-1:0]   data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [CNTW-1:0]   count_q, count_d;

    logic               out_free;
    logic               at_last;
    logic               in_ready_c;
    logic               accept;
    logic               pad_write;
    logic               wen;
    logic [INWIDTH-1:0] pad_word;
    logic [INWIDTH-1:0] wword;

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        buf_d   = buf_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        count_d = count_q;

        out_free   = !valid_q || blk_ready;
        at_last    = (wc_q == WC_LAST);
        in_ready_c = !clear && (state_q == COLLECT) && (!at_last || out_free);
        accept     = in_valid && in_ready_c;

        // First pad word carries the leading 1, the word in slot W-1 the trailing 1;
        // both land in one word when padding starts in the final slot.
        pad_word = '0;
        if (first_q) pad_word[0] = 1'b1;
        if (at_last) pad_word[INWIDTH-1] = 1'b1;

        pad_write = (state_q == PAD) && (!at_last || out_free);
        wen       = accept || pad_write;
        wword     = accept ? in_data : pad_word;

        if (blk_ready) valid_d = 1'b0;

        if (wen) begin
            if (at_last) begin
                data_d  = {wword, buf_q};
                valid_d = 1'b1;
                count_d = cnt_q;
                wc_d    = '0;
                if (state_q == PAD) begin
                    last_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end else begin
                    last_d = 1'b0;
                    cnt_d  = cnt_q + 1'b1;
                end
            end else begin
                buf_d[int'(wc_q)*INWIDTH +: INWIDTH] = wword;
                wc_d = wc_q + 1'b1;
            end

            if (state_q == PAD) begin
                first_d = 1'b0;
            end else if (in_last) begin
                // A last word that also fills the block starts padding on an empty buffer.
                state_d = PAD;
                first_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= COLLECT;
            wc_q    <= '0;
            buf_q   <= '0;
            first_q <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            buf_q   <= buf_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign blk_data  = data_q;
    assign blk_valid = valid_q;
    assign blk_last  = last_q;
    assign blk_count = count_q;
    assign busy      = (state_q == PAD) || (wc_q != '0);

endmodule
